ahb_resp_mux: RTL and testbench



---
 rtl/ahb_pkg.sv | 54 +++++
 rtl/ahb_default_slave.sv | 84 ++++++++
 rtl/ahb_resp_mux.sv | 148 ++++++++++++++
 tb/tb_ahb_resp_mux.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
//
// Shared AHB definitions used by the response multiplexer and default slave.
//   - AHB_DATA_BITS : data bus width (defaults to 32 if not set by the build)
//   - htrans_e      : master transfer type encoding
//   - hresp_e       : slave response encoding
//   - SLV_*         : bit positions of each slave inside the select vector
//   - SEL_*         : one-hot select vectors for each slave
//   - helpers       : one-hot test and "does this transfer carry data" test
// ---------------------------------------------------------------------------
`ifndef AHB_DATA_BITS
`define AHB_DATA_BITS 32
`endif

package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  // Bit positions inside the {S2, S1, DEF} select vector.
  localparam int SLV_DEF   = 0;
  localparam int SLV_S1    = 1;
  localparam int SLV_S2    = 2;
  localparam int SLV_COUNT = 3;

  typedef logic [SLV_COUNT-1:0] slv_sel_t;

  localparam slv_sel_t SEL_DEF = slv_sel_t'(1 << SLV_DEF);
  localparam slv_sel_t SEL_S1  = slv_sel_t'(1 << SLV_S1);
  localparam slv_sel_t SEL_S2  = slv_sel_t'(1 << SLV_S2);

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
  function automatic logic isOneHot(input slv_sel_t sel);
    return (sel != '0) && ((sel & (sel - slv_sel_t'(1))) == '0);
  endfunction

  // NONSEQ and SEQ are the only transfer types that need a real response.
  function automatic logic isActiveTrans(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
//
// Answers accesses that the address decoder could not map to a real slave.
// IDLE/BUSY transfers get a zero-wait OKAY; NONSEQ/SEQ transfers get the
// two-cycle ERROR response (ERROR with HREADYOUT low, then ERROR with
// HREADYOUT high), and a back-to-back unmapped transfer restarts the pair.
//
// Ports:
//   HCLK       in   system clock, rising edge
//   HRESET     in   asynchronous active-high reset
//   HSEL       in   this slave is addressed by the current address phase
//   HTRANS[1:0] in  master transfer type
//   HREADY     in   bus-wide HREADY (address phase completes when high)
//   HREADYOUT  out  this slave's ready
//   HRESP[1:0] out  this slave's response
// ---------------------------------------------------------------------------
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic [1:0] HRESP
);

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       unmappedStart;

  // An unmapped transfer only starts when its address phase actually
  // completes, i.e. the bus is ready at this edge.
  assign unmappedStart = HSEL && isActiveTrans(HTRANS) && HREADY;

  // ERR1 always advances to ERR2 because this slave itself holds HREADY low
  // in ERR1. ERR2 already drives HREADY high, so the next address phase
  // completes there and is evaluated exactly like one from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: state_d = unmappedStart ? DS_ERR1 : DS_IDLE;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = unmappedStart ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // State register; reset abandons any ERROR sequence in progress.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore outputs; the unused encoding behaves like IDLE.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      DS_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_ERROR;
      end
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
      end
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// ---------------------------------------------------------------------------
// ahb_resp_mux
//
// AHB slave-to-master response multiplexer. The decoder's slave selects are
// captured into a one-hot data-phase select (dsel) whenever the bus is ready;
// dsel then steers the owning slave's HRDATA/HREADY/HRESP to the master for
// the whole data phase. Unmapped accesses are answered by the embedded
// default slave (ahb_default_slave).
//
// Parameters:
//   DEF_RDATA   read data shown while the default slave owns the data phase
//
// Ports:
//   HCLK, HRESET             clock and asynchronous active-high reset
//   HSELDefault/HSEL_S1/_S2  decoder selects for the current address phase
//   HTRANS[1:0]              master transfer type
//   HRDATA_S1/_S2            slave read data
//   HREADY_S1/_S2            slave HREADYOUT
//   HRESP_S1/_S2             slave responses
//   HRDATA, HREADY, HRESP    muxed response to the master (HREADY also
//                            goes to every slave)
//   SEL_ERR                  sticky flag: a non-one-hot select was seen
//
// Build option:
//   AHB_RESP_MUX_SELCHK_EN   when defined, non-one-hot selects are routed to
//                            the default slave and raise SEL_ERR; otherwise
//                            selects are trusted and SEL_ERR is tied low.
// ---------------------------------------------------------------------------
`ifndef AHB_DATA_BITS
`define AHB_DATA_BITS 32
`endif

module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter logic [`AHB_DATA_BITS-1:0] DEF_RDATA = '0
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSELDefault,
  input  logic                      HSEL_S1,
  input  logic                      HSEL_S2,
  input  logic [1:0]                HTRANS,
  input  logic [`AHB_DATA_BITS-1:0] HRDATA_S1,
  input  logic [`AHB_DATA_BITS-1:0] HRDATA_S2,
  input  logic                      HREADY_S1,
  input  logic                      HREADY_S2,
  input  logic [1:0]                HRESP_S1,
  input  logic [1:0]                HRESP_S2,
  output logic [`AHB_DATA_BITS-1:0] HRDATA,
  output logic                      HREADY,
  output logic [1:0]                HRESP,
  output logic                      SEL_ERR
);

  slv_sel_t                  rawSel;
  slv_sel_t                  loadSel;
  slv_sel_t                  dsel_q;
  slv_sel_t                  dsel_d;
  logic                      defSel;
  logic                      defReady;
  logic [1:0]                defResp;
  logic                      busReady;
  logic [`AHB_DATA_BITS-1:0] muxData;
  logic [1:0]                muxResp;

  assign rawSel = {HSEL_S2, HSEL_S1, HSELDefault};

`ifdef AHB_RESP_MUX_SELCHK_EN
  logic selBad;
  logic selErr_q;
  logic selErr_d;

  // A broken select vector is turned into an unmapped access so the master
  // sees an ERROR instead of a mix of slave outputs.
  assign selBad  = !isOneHot(rawSel);
  assign loadSel = selBad ? SEL_DEF : rawSel;
  assign defSel  = HSELDefault || selBad;

  // The check only counts at edges where the address phase completes; the
  // flag then stays set until reset.
  always_comb begin
    selErr_d = selErr_q || (busReady && selBad);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      selErr_q <= 1'b0;
    end else begin
      selErr_q <= selErr_d;
    end
  end

  assign SEL_ERR = selErr_q;
`else
  assign loadSel = rawSel;
  assign defSel  = HSELDefault;
  assign SEL_ERR = 1'b0;
`endif

  // The pipelined address phase is only accepted when the current data phase
  // finishes, so dsel holds through wait states.
  always_comb begin
    dsel_d = busReady ? loadSel : dsel_q;
  end

  // Out of reset the default slave owns the bus, which yields an idle OKAY.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_q <= SEL_DEF;
    end else begin
      dsel_q <= dsel_d;
    end
  end

  ahb_default_slave u_defaultSlave (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (defSel),
    .HTRANS    (HTRANS),
    .HREADY    (busReady),
    .HREADYOUT (defReady),
    .HRESP     (defResp)
  );

  // Response steering from the registered select only, so slave inputs reach
  // the master with no added latency. Anything other than S1 or S2 falls
  // back to the default slave.
  always_comb begin
    muxData  = DEF_RDATA;
    busReady = defReady;
    muxResp  = defResp;
    if (dsel_q[SLV_S1]) begin
      muxData  = HRDATA_S1;
      busReady = HREADY_S1;
      muxResp  = HRESP_S1;
    end else if (dsel_q[SLV_S2]) begin
      muxData  = HRDATA_S2;
      busReady = HREADY_S2;
      muxResp  = HRESP_S2;
    end
  end

  assign HRDATA = muxData;
  assign HREADY = busReady;
  assign HRESP  = muxResp;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// ---------------------------------------------------------------------------
// tb_ahb_resp_mux
//
// Self-checking bench for ahb_resp_mux. A transaction-level model tracks who
// owns the current data phase and how far into an unmapped ERROR response
// it is; a compare process checks every output against it on each falling
// clock edge. Directed sequences pin the model with literal expectations,
// followed by a randomized run with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_ahb_resp_mux;
  import ahb_pkg::*;

  localparam int DW = `AHB_DATA_BITS;
  localparam logic [DW-1:0] TB_DEF_RDATA = DW'(32'hA5A5_0F0F);
  localparam logic [2:0] S_DEF = 3'b001;
  localparam logic [2:0] S_S1  = 3'b010;
  localparam logic [2:0] S_S2  = 3'b100;
`ifdef AHB_RESP_MUX_SELCHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          HSELDefault, HSEL_S1, HSEL_S2;
  logic [1:0]    HTRANS;
  logic [DW-1:0] HRDATA_S1, HRDATA_S2;
  logic          HREADY_S1, HREADY_S2;
  logic [1:0]    HRESP_S1, HRESP_S2;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic [1:0]    HRESP;
  logic          SEL_ERR;

  int compared = 0;
  int mismatched = 0;

  // Model state: owner of the data phase, ERROR progress (0 none, 1 first
  // wait cycle, 2 second cycle), sticky select-error flag.
  int mOwner = SLV_DEF;
  int mErr = 0;
  bit mSelErr = 1'b0;

  ahb_resp_mux #(.DEF_RDATA(TB_DEF_RDATA)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSELDefault(HSELDefault), .HSEL_S1(HSEL_S1), .HSEL_S2(HSEL_S2),
    .HTRANS(HTRANS),
    .HRDATA_S1(HRDATA_S1), .HRDATA_S2(HRDATA_S2),
    .HREADY_S1(HREADY_S1), .HREADY_S2(HREADY_S2),
    .HRESP_S1(HRESP_S1), .HRESP_S2(HRESP_S2),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .SEL_ERR(SEL_ERR)
  );

  always #5 HCLK = ~HCLK;

  function automatic int countSel(input logic [2:0] s);
    int n = 0;
    for (int i = 0; i < 3; i++) n += int'(s[i]);
    return n;
  endfunction

  function automatic int ownerFor(input logic [2:0] s);
    if (CHK_EN && countSel(s) != 1) return SLV_DEF;
    if (s[2]) return SLV_S2;
    if (s[1]) return SLV_S1;
    return SLV_DEF;
  endfunction

  function automatic bit unmappedFor(input logic [2:0] s, input logic [1:0] t);
    return t[1] && (s[0] || (CHK_EN && countSel(s) != 1));
  endfunction

  function automatic logic expReady();
    if (mOwner == SLV_S1) return HREADY_S1;
    if (mOwner == SLV_S2) return HREADY_S2;
    return (mErr != 1);
  endfunction

  function automatic logic [1:0] expResp();
    if (mOwner == SLV_S1) return HRESP_S1;
    if (mOwner == SLV_S2) return HRESP_S2;
    return (mErr != 0) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [DW-1:0] expData();
    if (mOwner == SLV_S1) return HRDATA_S1;
    if (mOwner == SLV_S2) return HRDATA_S2;
    return TB_DEF_RDATA;
  endfunction

  // Reference model: a new data phase starts whenever the bus was ready.
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      mOwner  <= SLV_DEF;
      mErr    <= 0;
      mSelErr <= 1'b0;
    end else if (expReady()) begin
      mOwner <= ownerFor({HSEL_S2, HSEL_S1, HSELDefault});
      mErr   <= unmappedFor({HSEL_S2, HSEL_S1, HSELDefault}, HTRANS) ? 1 : 0;
      if (CHK_EN && countSel({HSEL_S2, HSEL_S1, HSELDefault}) != 1) mSelErr <= 1'b1;
    end else if (mErr == 1) begin
      mErr <= 2;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkLiteral(input string name, input logic [DW-1:0] d, input logic r,
                              input logic [1:0] p, input logic e);
    checkOutput({name, ".HRDATA"}, 64'(HRDATA), 64'(d));
    checkOutput({name, ".HREADY"}, 64'(HREADY), 64'(r));
    checkOutput({name, ".HRESP"}, 64'(HRESP), 64'(p));
    checkOutput({name, ".SEL_ERR"}, 64'(SEL_ERR), 64'(e));
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      checkOutput("cyc.HRDATA", 64'(HRDATA), 64'(expData()));
      checkOutput("cyc.HREADY", 64'(HREADY), 64'(expReady()));
      checkOutput("cyc.HRESP", 64'(HRESP), 64'(expResp()));
      checkOutput("cyc.SEL_ERR", 64'(SEL_ERR), 64'(mSelErr));
    end
  end

  task automatic applyStimulus(input logic [2:0] s, input logic [1:0] t);
    {HSEL_S2, HSEL_S1, HSELDefault} = s;
    HTRANS = t;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    applyStimulus(S_DEF, HTRANS_IDLE);
    HRDATA_S1 = '0; HRDATA_S2 = '0;
    HREADY_S1 = 1'b1; HREADY_S2 = 1'b1;
    HRESP_S1 = 2'b00; HRESP_S2 = 2'b00;
    #1 checkLiteral("in_reset", TB_DEF_RDATA, 1'b1, 2'b00, 1'b0);
    tick(); tick();
    HRESET = 1'b0;
    tick();
    #1 checkLiteral("idle_bus", TB_DEF_RDATA, 1'b1, 2'b00, 1'b0);

    // Asynchronous reset in the middle of the first ERROR cycle.
    tick();
    applyStimulus(S_DEF, HTRANS_NONSEQ);
    tick();
    applyStimulus(S_DEF, HTRANS_IDLE);
    #1 checkLiteral("err1_pre_reset", TB_DEF_RDATA, 1'b0, 2'b01, 1'b0);
    HRESET = 1'b1;
    #1 checkLiteral("async_reset", TB_DEF_RDATA, 1'b1, 2'b00, 1'b0);
    tick();
    HRESET = 1'b0;

    // Zero-wait read from S1.
    HRDATA_S1 = DW'(32'hDEADBEEF);
    applyStimulus(S_S1, HTRANS_NONSEQ);
    tick();
    applyStimulus(S_DEF, HTRANS_IDLE);
    #1 checkLiteral("s1_read", DW'(32'hDEADBEEF), 1'b1, 2'b00, 1'b0);

    // S2 read with three wait states while S1 is addressed next.
    HRDATA_S1 = DW'(32'h1111_4444);
    HRDATA_S2 = DW'(32'h2222_3333);
    tick();
    applyStimulus(S_S2, HTRANS_NONSEQ);
    tick();
    applyStimulus(S_S1, HTRANS_NONSEQ);
    HREADY_S2 = 1'b0;
    #1 checkLiteral("s2_wait1", DW'(32'h2222_3333), 1'b0, 2'b00, 1'b0);
    tick();
    #1 checkLiteral("s2_wait2", DW'(32'h2222_3333), 1'b0, 2'b00, 1'b0);
    tick();
    #1 checkLiteral("s2_wait3", DW'(32'h2222_3333), 1'b0, 2'b00, 1'b0);
    tick();
    HREADY_S2 = 1'b1;
    #1 checkLiteral("s2_done", DW'(32'h2222_3333), 1'b1, 2'b00, 1'b0);
    tick();
    applyStimulus(S_DEF, HTRANS_IDLE);
    #1 checkLiteral("s1_after_wait", DW'(32'h1111_4444), 1'b1, 2'b00, 1'b0);

    // Unmapped NONSEQ followed back-to-back by an unmapped SEQ, then IDLE.
    tick();
    applyStimulus(S_DEF, HTRANS_NONSEQ);
    tick();
    applyStimulus(S_DEF, HTRANS_SEQ);
    #1 checkLiteral("unm_err1", TB_DEF_RDATA, 1'b0, 2'b01, 1'b0);
    tick();
    #1 checkLiteral("unm_err2", TB_DEF_RDATA, 1'b1, 2'b01, 1'b0);
    tick();
    applyStimulus(S_DEF, HTRANS_IDLE);
    #1 checkLiteral("b2b_err1", TB_DEF_RDATA, 1'b0, 2'b01, 1'b0);
    tick();
    #1 checkLiteral("b2b_err2", TB_DEF_RDATA, 1'b1, 2'b01, 1'b0);
    tick();
    #1 checkLiteral("def_idle", TB_DEF_RDATA, 1'b1, 2'b00, 1'b0);

    // Pipelined S1 -> S2 -> S1, zero wait; S2 answers SPLIT unmodified.
    HRDATA_S1 = DW'(32'h0101_A0A0);
    HRDATA_S2 = DW'(32'h0202_B0B0);
    applyStimulus(S_S1, HTRANS_NONSEQ);
    tick();
    applyStimulus(S_S2, HTRANS_NONSEQ);
    #1 checkLiteral("pipe_s1a", DW'(32'h0101_A0A0), 1'b1, 2'b00, 1'b0);
    tick();
    applyStimulus(S_S1, HTRANS_NONSEQ);
    HRESP_S2 = 2'b11;
    #1 checkLiteral("pipe_s2", DW'(32'h0202_B0B0), 1'b1, 2'b11, 1'b0);
    tick();
    applyStimulus(S_DEF, HTRANS_IDLE);
    HRESP_S2 = 2'b00;
    #1 checkLiteral("pipe_s1b", DW'(32'h0101_A0A0), 1'b1, 2'b00, 1'b0);
    tick();

`ifdef AHB_RESP_MUX_SELCHK_EN
    // Double select on a NONSEQ: ERROR pair and a sticky SEL_ERR.
    applyStimulus(3'b110, HTRANS_NONSEQ);
    tick();
    applyStimulus(S_DEF, HTRANS_IDLE);
    #1 checkLiteral("selchk_err1", TB_DEF_RDATA, 1'b0, 2'b01, 1'b1);
    tick();
    #1 checkLiteral("selchk_err2", TB_DEF_RDATA, 1'b1, 2'b01, 1'b1);
    repeat (3) tick();
    #1 checkLiteral("selchk_sticky", TB_DEF_RDATA, 1'b1, 2'b00, 1'b1);
    HRESET = 1'b1;
    #1 checkLiteral("selchk_cleared", TB_DEF_RDATA, 1'b1, 2'b00, 1'b0);
    tick();
    HRESET = 1'b0;
`endif

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (CHK_EN && $urandom_range(0, 9) == 0)
        applyStimulus(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      else
        applyStimulus(3'(1 << $urandom_range(0, 2)), 2'($urandom_range(0, 3)));
      HRDATA_S1 = DW'($urandom());
      HRDATA_S2 = DW'($urandom());
      HREADY_S1 = ($urandom_range(0, 3) != 0);
      HREADY_S2 = ($urandom_range(0, 3) != 0);
      HRESP_S1  = 2'($urandom_range(0, 3));
      HRESP_S2  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
      end
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
